// File: rtl/pri_codec_pkg.sv
// Shared types and helpers for the priority encode/decode path.
// State enum, default index/one-hot widths and the index-to-one-hot helper.
package pri_codec_pkg;

    localparam int unsigned PRI_WIDTH_IN  = 4;
    localparam int unsigned PRI_WIDTH_OUT = 16;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StGap
    } pri_state_e;

    function automatic logic [PRI_WIDTH_OUT-1:0] onehot_of(input logic [PRI_WIDTH_IN-1:0] index);
        return PRI_WIDTH_OUT'(1) << index;
    endfunction

endpackage

// File: rtl/pri_hold_counter.sv
// Loadable down-counter with synchronous clear; stops at zero and flags it.
module pri_hold_counter #(
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    input  logic                dec_i,
    output logic                zero_o
);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pri_decoder_hold_fsm.sv
// Binary index to registered one-hot, held for HOLD_CYCLES cycles per accept.
// Define PRI_DECODER_GAP_EN to insert a one-cycle zero gap after every hold.
module pri_decoder_hold_fsm
    import pri_codec_pkg::*;
#(
    parameter int unsigned WIDTH_IN    = PRI_WIDTH_IN,
    parameter int unsigned WIDTH_OUT   = PRI_WIDTH_OUT,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [WIDTH_IN-1:0]  binary_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH_OUT-1:0] decoder_out,
    output logic                 out_valid,
    output logic                 busy
);

    if (WIDTH_OUT != (2 ** WIDTH_IN)) begin : g_bad_width
        $error("WIDTH_OUT must equal 2**WIDTH_IN");
    end
    if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..255");
    end

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

    pri_state_e           state_q, state_d;
    logic [WIDTH_OUT-1:0] dout_q, dout_d;
    logic                 ov_q, ov_d;
    logic                 cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic                 accept;
    logic [WIDTH_OUT-1:0] grant_onehot;

    assign grant_onehot = WIDTH_OUT'(onehot_of(PRI_WIDTH_IN'(binary_in)));

`ifdef PRI_DECODER_GAP_EN
    assign in_ready = enable && (state_q == StIdle);
`else
    // The last hold cycle may accept, giving back-to-back grants with no bubble.
    assign in_ready = enable && ((state_q == StIdle) || ((state_q == StDrive) && cnt_zero));
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        ov_d     = ov_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        if (!enable) begin
            state_d = StIdle;
            dout_d  = '0;
            ov_d    = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d  = StDrive;
                        dout_d   = grant_onehot;
                        ov_d     = 1'b1;
                        cnt_load = 1'b1;
                    end
                end
                StDrive: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
`ifdef PRI_DECODER_GAP_EN
                        state_d = StGap;
                        dout_d  = '0;
                        ov_d    = 1'b0;
`else
                        if (accept) begin
                            dout_d   = grant_onehot;
                            ov_d     = 1'b1;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = StIdle;
                            dout_d  = '0;
                            ov_d    = 1'b0;
                        end
`endif
                    end
                end
`ifdef PRI_DECODER_GAP_EN
                StGap: begin
                    state_d = StIdle;
                end
`endif
                default: begin
                    state_d = StIdle;
                    dout_d  = '0;
                    ov_d    = 1'b0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            dout_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            ov_q    <= ov_d;
        end
    end

    pri_hold_counter #(
        .CntWidth(8)
    ) u_hold_counter (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .clr_i     (cnt_clr),
        .load_i    (cnt_load),
        .load_val_i(HoldLoad),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    assign decoder_out = dout_q;
    assign out_valid   = ov_q;
    assign busy        = (state_q != StIdle);

endmodule
